inst_sram_responder: RTL and testbench
======================================

// Module: inst_sram_responder
// PURPOSE
// Responder end of the sram-style bus that the fetch stage drives (en/wen/addr/wdata out, rdata back).
// Serves requests from a local word-organised memory with programmable wait states.
// Generates stall_req back to the pipeline stall logic so the requester holds its request.
// Used as on-chip boot/instruction memory and as a latency model for fetch verification.
// PARAMETERS
// ADDR_W       14            word-index bits; memory depth = 2**ADDR_W words (default 64 KB)
// BASE_PADDR   32'h1FC0_0000 physical base of the memory window; must be aligned to its 4*2**ADDR_W size
// PADDR_MASK   32'h1FFF_FFFF virtual->physical mask (kseg0/kseg1 unmapped translation)
// WAIT_CYCLES  0             stall cycles inserted per access (0..15)
// PORTS
// clk          in   1   clock, rising edge
// rst          in   1   asynchronous, active-high reset
// sram_en      in   1   request valid
// sram_wen     in   4   byte write enables; 4'b0000 = read
// sram_addr    in   32  virtual byte address; [1:0] ignored
// sram_wdata   in   32  write data, lane i = bits [8i+7:8i]
// sram_rdata   out  32  read data
// stall_req    out  1   requester must hold en/wen/addr/wdata stable while high
// addr_err     out  1   one-cycle pulse: accepted access fell outside the window
// BEHAVIOUR
// - Reset values: sram_rdata=0, stall_req=0, addr_err=0, FSM=IDLE, wait counter=0.
// - Reset is async in both directions of effect; memory array is not cleared.
// - paddr = sram_addr & PADDR_MASK; idx = paddr[ADDR_W+1:2].
// - hit = (paddr[31:ADDR_W+2] == BASE_PADDR[31:ADDR_W+2]).
// - Acceptance: rising edge where sram_en=1 and stall_req=0. Only accepted requests have effects.
// - Read accepted at edge k: sram_rdata = mem[idx] (or 0 on miss) from cycle k+1.
// - Read data is held until the next accepted read.
// - Write accepted at edge k: mem[idx] byte lanes with wen[i]=1 take wdata lanes; other lanes keep their value.
// - A write has no effect on sram_rdata. A write on a miss is dropped.
// - Miss on any accepted access: addr_err=1 for exactly cycle k+1.
// - WAIT_CYCLES=0: FSM stays IDLE, stall_req constant 0, every en cycle is accepted (back-to-back, 1 access/cycle).
// - WAIT_CYCLES=W>0: FSM states IDLE, WAIT.
//   - IDLE, en=1: stall_req=1 (combinational from en); next state WAIT with cnt=W-1.
//   - IDLE, en=0: stall_req=0; stay IDLE.
//   - WAIT, cnt!=0: stall_req=1; cnt decrements.
//   - WAIT, cnt==0: stall_req=0; the request is accepted at that edge; next state IDLE.
//   - Net: exactly W stall cycles, then acceptance. Each access costs W+1 cycles.
//   - In WAIT, en=0 abandons the request: next state IDLE, no memory or rdata effect, stall_req=0 that cycle.
// - Address/wen/wdata are sampled at the acceptance edge, not at entry to WAIT.
// - Reset asserted mid-WAIT: stall_req drops immediately; the pending access is discarded.
// - Counter width: 4 bits. Elaboration must fail (generate error) if WAIT_CYCLES>15 or BASE_PADDR is misaligned.
// TESTING
// - W=0, mem[0]=32'h2402_0001, en=1 addr=32'hBFC0_0000 at edge k -> rdata=32'h2402_0001 in cycle k+1, stall_req always 0.
// - W=0, back-to-back reads of BFC00000/BFC00004/BFC00008 -> rdata returns the three words on consecutive cycles.
// - Write 32'hAABBCCDD to 9FC00010 with wen=4'b0101 over existing 32'h11223344 -> read of BFC00010 returns 32'h11BB33DD.
// - W=3, hold a read of BFC00004 -> stall_req high exactly 3 cycles; rdata updates the cycle after stall_req falls.
// - W=3, drop en after 1 stall cycle -> FSM IDLE, stall_req 0, rdata unchanged. Assert rst mid-WAIT -> stall_req 0 and rdata 0 immediately.
// - Read 32'h8000_0000 (miss) -> rdata=0 and addr_err=1 for one cycle. Write to the same miss address -> memory unchanged.

Source files
------------

// File: rtl/inst_sram_responder.sv
// Instruction-side SRAM responder: word-organised local memory behind the fetch
// stage's sram bus, with a programmable number of wait states per access.
module inst_sram_responder #(
  parameter int unsigned ADDR_W      = 14,
  parameter logic [31:0] BASE_PADDR  = 32'h1FC0_0000,
  parameter logic [31:0] PADDR_MASK  = 32'h1FFF_FFFF,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sram_en,
  input  logic [3:0]  sram_wen,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  output logic        stall_req,
  output logic        addr_err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  generate
    if (WAIT_CYCLES > 15) begin : g_bad_wait
      $error("inst_sram_responder: WAIT_CYCLES must be 0..15");
    end
    if ((BASE_PADDR & ((32'd4 << ADDR_W) - 32'd1)) != 32'd0) begin : g_bad_base
      $error("inst_sram_responder: BASE_PADDR not aligned to window size");
    end
  endgenerate

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [31:0]       paddr;
  logic [ADDR_W-1:0] idx;
  logic              hit;
  logic              accept;
  logic [31:0]       mem [DEPTH];
  logic              unused_lsb;

  assign paddr      = sram_addr & PADDR_MASK;
  assign idx        = paddr[ADDR_W+1:2];
  assign hit        = (paddr[31:ADDR_W+2] == BASE_PADDR[31:ADDR_W+2]);
  assign unused_lsb = ^paddr[1:0];

  // Stall is combinational from en so the requester sees it in the request cycle;
  // reset forces it low immediately, abandoning any pending access.
  always_comb begin
    stall_req = 1'b0;
    if (WAIT_CYCLES != 0 && !rst) begin
      if (state == S_IDLE) stall_req = sram_en;
      else                 stall_req = sram_en && (cnt != 4'd0);
    end
  end

  assign accept = sram_en && !stall_req && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else if (WAIT_CYCLES != 0) begin
      case (state)
        S_IDLE: begin
          if (sram_en) begin
            state <= S_WAIT;
            cnt   <= WAIT_INIT;
          end
        end
        S_WAIT: begin
          if (!sram_en) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

  // Response stage: read data held until the next accepted read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_rdata <= 32'd0;
      addr_err   <= 1'b0;
    end else begin
      addr_err <= accept && !hit;
      if (accept && (sram_wen == 4'b0000)) begin
        sram_rdata <= hit ? mem[idx] : 32'd0;
      end
    end
  end

  // Memory contents survive reset; writes outside the window are dropped.
  always_ff @(posedge clk) begin
    if (accept && hit) begin
      for (int i = 0; i < 4; i++) begin
        if (sram_wen[i]) mem[idx][8*i +: 8] <= sram_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_inst_sram_responder.sv
// Bench for inst_sram_responder: one zero-wait and one three-wait instance,
// directed cases plus randomized accesses against a window-level memory model.
module tb_inst_sram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        en    [2];
  logic [3:0]  wen   [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        stall [2];
  logic        err   [2];

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] mm [2][16];
  logic [31:0] exp_rd [2];

  always #5 clk = ~clk;

  inst_sram_responder #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .sram_en(en[0]), .sram_wen(wen[0]), .sram_addr(addr[0]),
    .sram_wdata(wdata[0]), .sram_rdata(rdata[0]), .stall_req(stall[0]), .addr_err(err[0])
  );

  inst_sram_responder #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .sram_en(en[1]), .sram_wen(wen[1]), .sram_addr(addr[1]),
    .sram_wdata(wdata[1]), .sram_rdata(rdata[1]), .stall_req(stall[1]), .addr_err(err[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // The window is the 64 KB region starting at physical 0x1FC00000.
  function automatic bit in_win(input logic [31:0] a);
    logic [31:0] p;
    p = a & 32'h1FFF_FFFF;
    return (p >= 32'h1FC0_0000) && (p < 32'h1FC1_0000);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'(((a & 32'h1FFF_FFFF) - 32'h1FC0_0000) / 4);
  endfunction

  // Entered just after a rising edge; returns just after the acceptance edge.
  task automatic access(input int d, input logic [3:0] w, input logic [31:0] a,
                        input logic [31:0] wd);
    int stalls;
    bit hit;
    int ix;
    stalls = 0;
    en[d] = 1'b1; wen[d] = w; addr[d] = a; wdata[d] = wd;
    for (int g = 0; g < 20; g++) begin
      #2;
      if (!stall[d]) break;
      stalls++;
      chk("rdata_during_stall", rdata[d], exp_rd[d]);
      @(posedge clk); #1;
    end
    chk("stall_cycles", 32'(stalls), (d == 0) ? 32'd0 : 32'd3);
    @(posedge clk); #1;
    hit = in_win(a);
    ix  = hit ? word_of(a) : 0;
    if (w == 4'b0000) begin
      exp_rd[d] = hit ? mm[d][ix] : 32'd0;
    end else if (hit) begin
      for (int i = 0; i < 4; i++) if (w[i]) mm[d][ix][8*i +: 8] = wd[8*i +: 8];
    end
    chk("rdata", rdata[d], exp_rd[d]);
    chk("addr_err", 32'(err[d]), 32'(!hit));
    en[d] = 1'b0;
  endtask

  task automatic idle(input int n);
    en[0] = 1'b0; en[1] = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        chk("idle_err", 32'(err[d]), 32'd0);
        chk("idle_rdata", rdata[d], exp_rd[d]);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic [3:0]  w;
    int          d;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      en[i] = 1'b0; wen[i] = 4'd0; addr[i] = 32'd0; wdata[i] = 32'd0; exp_rd[i] = 32'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("reset_rdata", rdata[i], 32'd0);
      chk("reset_stall", 32'(stall[i]), 32'd0);
      chk("reset_err", 32'(err[i]), 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Preload the first 16 words of both memories.
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 16; j++)
        access(i, 4'hF, 32'hBFC0_0000 + 32'(4 * j), $urandom);

    access(0, 4'hF, 32'hBFC0_0000, 32'h2402_0001);
    access(0, 4'h0, 32'hBFC0_0000, 32'd0);
    chk("boot_word", rdata[0], 32'h2402_0001);

    access(0, 4'h0, 32'hBFC0_0000, 32'd0);
    access(0, 4'h0, 32'hBFC0_0004, 32'd0);
    access(0, 4'h0, 32'hBFC0_0008, 32'd0);

    access(0, 4'hF, 32'h9FC0_0010, 32'h1122_3344);
    access(0, 4'b0101, 32'h9FC0_0010, 32'hAABB_CCDD);
    access(0, 4'h0, 32'hBFC0_0010, 32'd0);
    chk("byte_merge", rdata[0], 32'h11BB_33DD);

    for (int i = 0; i < 2; i++) begin
      access(i, 4'h0, 32'h8000_0000, 32'd0);
      idle(1);
      access(i, 4'hF, 32'h8000_0000, 32'hDEAD_BEEF);
      access(i, 4'h0, 32'hBFC0_0000, 32'd0);
    end

    access(1, 4'h0, 32'hBFC0_0004, 32'd0);

    // Abandon a waiting request after one stall cycle.
    en[1] = 1'b1; wen[1] = 4'h0; addr[1] = 32'hBFC0_0008;
    #1 chk("abandon_stall_idle", 32'(stall[1]), 32'd1);
    @(posedge clk); #1;
    en[1] = 1'b0;
    #1 chk("abandon_stall_drop", 32'(stall[1]), 32'd0);
    @(posedge clk); #1;
    chk("abandon_rdata", rdata[1], exp_rd[1]);
    chk("abandon_err", 32'(err[1]), 32'd0);
    access(1, 4'h0, 32'hBFC0_000C, 32'd0);

    // Reset while waiting.
    en[1] = 1'b1; wen[1] = 4'h0; addr[1] = 32'hBFC0_0004;
    @(posedge clk); #1;
    #1 chk("pre_reset_stall", 32'(stall[1]), 32'd1);
    rst = 1'b1;
    #1;
    chk("reset_wait_stall", 32'(stall[1]), 32'd0);
    chk("reset_wait_rdata", rdata[1], 32'd0);
    chk("reset_other_rdata", rdata[0], 32'd0);
    exp_rd[0] = 32'd0; exp_rd[1] = 32'd0;
    @(posedge clk); #1;
    en[1] = 1'b0;
    rst = 1'b0;
    idle(1);
    access(1, 4'h0, 32'hBFC0_0004, 32'd0);

    for (int n = 0; n < 250; n++) begin
      d = int'($urandom_range(0, 1));
      w = ($urandom_range(0, 9) < 5) ? 4'h0 : 4'($urandom_range(1, 15));
      a = ($urandom_range(0, 1) == 0) ? 32'h8000_0000 : 32'hA000_0000;
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(0, 255) * 4);
      else a = a + 32'h1FC0_0000 + 32'($urandom_range(0, 15) * 4);
      a = a + 32'($urandom_range(0, 3));
      access(d, w, a, $urandom);
      if ($urandom_range(0, 4) == 0) idle(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
